apb_mem_completer: RTL

- APB3 completer (slave) holding a small word-addressed register memory.
- Serves the read bursts issued by the team's APB requester (address counter, SETUP/ACCESS sequencing, pready/pslverr sampling).
- Adds programmable wait states, an error response for out-of-range addresses, and a completed-transfer counter.
- Sits on the peripheral bus as the target that feeds prdata back to the requester.

---
 rtl/apb_mem_completer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/apb_mem_completer.sv
// APB3 completer backed by a small word-addressed register memory, with
// programmable wait states, out-of-range error response and a transfer counter.
// Optional macro APB_MEM_RO_UPPER_EN makes the upper half of the memory read-only.
module apb_mem_completer #(
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0,
    parameter int CNT_W       = 16
) (
    input  logic             pclk_i,
    input  logic             presetn_i,
    input  logic             psel_i,
    input  logic             penable_i,
    input  logic             pwrite_i,
    input  logic [7:0]       paddr_i,
    input  logic [31:0]      pwdata_i,
    output logic [31:0]      prdata_o,
    output logic             pready_o,
    output logic             pslverr_o,
    output logic [CNT_W-1:0] xfer_cnt_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t             state_q, state_d;
    logic [3:0]         wcnt_q, wcnt_d;
    logic [7:0]         addr_q, addr_d;
    logic               write_q, write_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        mem_q [DEPTH];

    logic               addr_err;
    logic               xfer_err;
    logic               completion;
    logic               commit;
    logic [31:0]        rd_word;

    assign addr_err = ({1'b0, addr_q} >= 9'(DEPTH));
`ifdef APB_MEM_RO_UPPER_EN
    assign xfer_err = addr_err || (write_q && ({1'b0, addr_q} >= 9'(DEPTH / 2)));
`else
    assign xfer_err = addr_err;
`endif

    assign completion = (state_q == ST_RESP) && psel_i && penable_i;
    assign commit     = completion && write_q && !xfer_err;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (psel_i && !penable_i) begin
                    addr_d  = paddr_i;
                    write_d = pwrite_i;
                    wdata_d = pwdata_i;
                    wcnt_d  = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (!psel_i) begin
                    state_d = ST_IDLE;
                    wcnt_d  = 4'd0;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                    if (wcnt_q == 4'd1) state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (!psel_i) begin
                    state_d = ST_IDLE;
                end else if (penable_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            state_q <= ST_IDLE;
            wcnt_q  <= 4'd0;
            addr_q  <= 8'd0;
            write_q <= 1'b0;
            wdata_q <= 32'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Each word resets to its own index, so the memory cannot map onto a RAM macro.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            always_ff @(posedge pclk_i or negedge presetn_i) begin
                if (!presetn_i) begin
                    mem_q[gi] <= 32'(gi);
                end else if (commit && (addr_q == 8'(gi))) begin
                    mem_q[gi] <= wdata_q;
                end
            end
        end
    endgenerate

    always_comb begin
        rd_word = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr_q == 8'(i)) rd_word = mem_q[i];
        end
    end

    assign pready_o   = (state_q == ST_RESP);
    assign pslverr_o  = pready_o && xfer_err;
    assign prdata_o   = (pready_o && !write_q && !addr_err) ? rd_word : 32'd0;
    assign xfer_cnt_o = cnt_q;

endmodule
